// File: rtl/csr_trap_file.sv
// csr_trap_file: machine-mode CSRs, trap/MRET sequencing and interrupt arbitration.
// Define CSR_COUNTERS_EN to build the mcycle/minstret counters.
module csr_trap_file #(
  parameter int          CNT_W     = 64,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL  = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret_valid,
  input  logic        instr_retire,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        irq_sw,
  output logic        irq_pending,
  output logic [31:0] irq_cause,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] mstatus_out
);
  logic        r_mie, r_mpie;
  logic [1:0]  r_mpp;
  logic        r_ie_e, r_ie_t, r_ie_s;
  logic        r_mip_e, r_mip_t, r_mip_s;
  logic [31:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval, r_redir_pc;
  logic        r_redir;
  logic [31:0] w_mstatus, w_mie, w_mip, w_rd, w_new, w_base;
  logic        w_impl, w_ro, w_busy, w_we;
  logic [11:0] w_pend;
  logic [4:0]  w_code;
`ifdef CSR_COUNTERS_EN
  logic [CNT_W-1:0] r_mcycle, r_minstret;
  logic [31:0]      w_cyc_hi, w_ret_hi;
  assign w_cyc_hi = 32'(r_mcycle >> 32);
  assign w_ret_hi = 32'(r_minstret >> 32);
`else
  logic w_unused;
  assign w_unused = instr_retire ^ (CNT_W > 0);
`endif
  assign w_mstatus = {19'b0, r_mpp, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
  assign w_mie     = {20'b0, r_ie_e, 3'b0, r_ie_t, 3'b0, r_ie_s, 3'b0};
  assign w_mip     = {20'b0, r_mip_e, 3'b0, r_mip_t, 3'b0, r_mip_s, 3'b0};
  assign w_base    = {r_mtvec[31:2], 2'b00};
  always_comb begin
    w_rd   = '0;
    w_impl = 1'b1;
    w_ro   = 1'b0;
    case (csr_addr)
      12'h300: w_rd = w_mstatus;
      12'h301: begin w_rd = MISA_VAL; w_ro = 1'b1; end
      12'h304: w_rd = w_mie;
      12'h305: w_rd = r_mtvec;
      12'h340: w_rd = r_mscratch;
      12'h341: w_rd = r_mepc;
      12'h342: w_rd = r_mcause;
      12'h343: w_rd = r_mtval;
      12'h344: begin w_rd = w_mip; w_ro = 1'b1; end
`ifdef CSR_COUNTERS_EN
      12'hB00: w_rd = r_mcycle[31:0];
      12'hB80: w_rd = w_cyc_hi;
      12'hB02: w_rd = r_minstret[31:0];
      12'hB82: w_rd = w_ret_hi;
`endif
      default: w_impl = 1'b0;
    endcase
  end
  assign w_new = csr_op == 2'b01 ? csr_wdata : csr_op == 2'b10 ? w_rd | csr_wdata : w_rd & ~csr_wdata;
  // Trap and MRET pre-empt the CSR access, so a dropped access never faults.
  assign w_busy      = trap_valid | mret_valid;
  assign csr_illegal = !rst && csr_op != 2'b00 && !w_busy && (!w_impl || (w_ro && w_new != w_rd));
  assign w_we        = csr_op != 2'b00 && !w_busy && w_impl && !w_ro;
  assign csr_rdata   = csr_op != 2'b00 ? w_rd : '0;
  assign w_pend      = w_mip[11:0] & w_mie[11:0];
  assign w_code      = w_pend[11] ? 5'd11 : w_pend[3] ? 5'd3 : w_pend[7] ? 5'd7 : 5'd0;
  assign irq_pending = r_mie & |w_pend;
  assign irq_cause   = {1'b1, 26'b0, w_code};
  assign redirect_valid = r_redir;
  assign redirect_pc    = r_redir_pc;
  assign mstatus_out    = w_mstatus;
  always_ff @(posedge clk or posedge rst)
    if (rst) {r_mip_e, r_mip_t, r_mip_s} <= '0;
    else     {r_mip_e, r_mip_t, r_mip_s} <= {irq_ext, irq_timer, irq_sw};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mpp      <= 2'b11;
      {r_ie_e, r_ie_t, r_ie_s} <= '0;
      r_mtvec    <= MTVEC_RST;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
      r_redir    <= 1'b0;
      r_redir_pc <= '0;
    end else begin
      r_redir <= w_busy;
      if (trap_valid) begin
        r_mepc     <= {trap_pc[31:2], 2'b00};
        r_mcause   <= trap_cause;
        r_mtval    <= trap_tval;
        r_mpie     <= r_mie;
        r_mie      <= 1'b0;
        r_mpp      <= 2'b11;
        r_redir_pc <= r_mtvec[0] && trap_cause[31] ? w_base + {25'b0, trap_cause[4:0], 2'b00} : w_base;
      end else if (mret_valid) begin
        r_mie      <= r_mpie;
        r_mpie     <= 1'b1;
        r_mpp      <= 2'b11;
        r_redir_pc <= r_mepc;
      end else if (w_we)
        case (csr_addr)
          12'h300: begin r_mie <= w_new[3]; r_mpie <= w_new[7]; r_mpp <= w_new[12:11]; end
          12'h304: {r_ie_e, r_ie_t, r_ie_s} <= {w_new[11], w_new[7], w_new[3]};
          12'h305: r_mtvec <= {w_new[31:2], w_new[1] ? 2'b00 : w_new[1:0]};
          12'h340: r_mscratch <= w_new;
          12'h341: r_mepc <= {w_new[31:2], 2'b00};
          12'h342: r_mcause <= w_new;
          12'h343: r_mtval <= w_new;
          default: ;
        endcase
    end
`ifdef CSR_COUNTERS_EN
  // A write to either half replaces that cycle's increment.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      r_mcycle   <= w_we && csr_addr == 12'hB00 ? {r_mcycle[CNT_W-1:32], w_new} :
                    w_we && csr_addr == 12'hB80 ? {w_new[CNT_W-33:0], r_mcycle[31:0]} :
                    r_mcycle + CNT_W'(1);
      r_minstret <= w_we && csr_addr == 12'hB02 ? {r_minstret[CNT_W-1:32], w_new} :
                    w_we && csr_addr == 12'hB82 ? {w_new[CNT_W-33:0], r_minstret[31:0]} :
                    r_minstret + CNT_W'(instr_retire);
    end
`endif
endmodule

// File: tb/tb_csr_trap_file.sv
// tb_csr_trap_file: scenario tasks with a queue of expected values for csr_trap_file.
module tb_csr_trap_file;
  logic        clk = 1'b0, rst = 1'b1;
  logic [1:0]  csr_op = '0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0, csr_rdata;
  logic        csr_illegal;
  logic        trap_valid = 1'b0, mret_valid = 1'b0, instr_retire = 1'b0;
  logic [31:0] trap_cause = '0, trap_pc = '0, trap_tval = '0;
  logic        irq_ext = 1'b0, irq_timer = 1'b0, irq_sw = 1'b0;
  logic        irq_pending, redirect_valid;
  logic [31:0] irq_cause, redirect_pc, mstatus_out;
  logic [31:0] exp_q[$];
  logic [31:0] got, e;
  logic        ill;
  int          n_vec = 0, n_err = 0;
  csr_trap_file dut (
    .clk(clk), .rst(rst), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .trap_valid(trap_valid),
    .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval), .mret_valid(mret_valid),
    .instr_retire(instr_retire), .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
    .irq_pending(irq_pending), .irq_cause(irq_cause), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mstatus_out(mstatus_out)
  );
  always #5 clk = ~clk;
  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    @(negedge clk);
    csr_op = 2'b10; csr_addr = a; csr_wdata = '0;
    #1 d = csr_rdata;
    csr_op = 2'b00;
  endtask
  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] v, output logic i);
    @(negedge clk);
    csr_op = op; csr_addr = a; csr_wdata = v;
    #1 i = csr_illegal;
    @(posedge clk);
    #1 csr_op = 2'b00;
  endtask
  task automatic trap(input logic [31:0] cause, input logic [31:0] pc);
    @(negedge clk);
    trap_valid = 1'b1; trap_cause = cause; trap_pc = pc; trap_tval = 32'hBAD0_0000 | pc;
    @(posedge clk);
    #1 trap_valid = 1'b0;
  endtask
  task automatic test_reset;
    csr_op = 2'b01; csr_addr = 12'h7FF; irq_timer = 1'b1;
    #23;
    exp_q.push_back(0); n_vec++; e = exp_q.pop_front();
    if ({31'b0, csr_illegal} !== e) begin n_err++; $display("FAIL rst_illegal got %h exp %h", csr_illegal, e); end
    exp_q.push_back(0); n_vec++; e = exp_q.pop_front();
    if ({31'b0, irq_pending | redirect_valid} !== e) begin n_err++; $display("FAIL rst_pend_redir got %b/%b exp 0", irq_pending, redirect_valid); end
    @(negedge clk);
    rst = 1'b0; csr_op = 2'b00; irq_timer = 1'b0;
    exp_q.push_back(32'h0000_1800); rd(12'h300, got); n_vec++; e = exp_q.pop_front();
    if (got !== e) begin n_err++; $display("FAIL rst_mstatus got %h exp %h", got, e); end
    exp_q.push_back(32'h0); rd(12'h305, got); n_vec++; e = exp_q.pop_front();
    if (got !== e) begin n_err++; $display("FAIL rst_mtvec got %h exp %h", got, e); end
    exp_q.push_back(32'h4000_0100); rd(12'h301, got); n_vec++; e = exp_q.pop_front();
    if (got !== e) begin n_err++; $display("FAIL rst_misa got %h exp %h", got, e); end
  endtask
  task automatic test_mtvec_warl;
    exp_q.push_back(0); wr(2'b01, 12'h305, 32'h0000_1003, ill); n_vec++; e = exp_q.pop_front();
    if ({31'b0, ill} !== e) begin n_err++; $display("FAIL mtvec_ill got %b exp 0", ill); end
    exp_q.push_back(32'h0000_1000); rd(12'h305, got); n_vec++; e = exp_q.pop_front();
    if (got !== e) begin n_err++; $display("FAIL mtvec_mode3 got %h exp %h", got, e); end
    wr(2'b01, 12'h305, 32'h0000_0202, ill);
    exp_q.push_back(32'h0000_0200); rd(12'h305, got); n_vec++; e = exp_q.pop_front();
    if (got !== e) begin n_err++; $display("FAIL mtvec_mode2 got %h exp %h", got, e); end
  endtask
  task automatic test_irq_trap;
    wr(2'b01, 12'h305, 32'h0000_0100, ill);
    wr(2'b01, 12'h300, 32'h0000_0008, ill);
    wr(2'b01, 12'h304, 32'h0000_0080, ill);
    @(negedge clk);
    irq_timer = 1'b1;
    exp_q.push_back(0);
    #1 n_vec++; e = exp_q.pop_front();
    if ({31'b0, irq_pending} !== e) begin n_err++; $display("FAIL irq_early got %b exp 0", irq_pending); end
    exp_q.push_back(1); exp_q.push_back(32'h8000_0007);
    @(posedge clk);
    #1 n_vec++; e = exp_q.pop_front();
    if ({31'b0, irq_pending} !== e) begin n_err++; $display("FAIL irq_pend got %b exp 1", irq_pending); end
    n_vec++; e = exp_q.pop_front();
    if (irq_cause !== e) begin n_err++; $display("FAIL irq_cause got %h exp %h", irq_cause, e); end
    exp_q.push_back(1); exp_q.push_back(32'h0000_0100); exp_q.push_back(0);
    trap(32'h8000_0007, 32'h0000_0102);
    n_vec++; e = exp_q.pop_front();
    if ({31'b0, redirect_valid} !== e) begin n_err++; $display("FAIL trap_rv got %b exp 1", redirect_valid); end
    n_vec++; e = exp_q.pop_front();
    if (redirect_pc !== e) begin n_err++; $display("FAIL trap_rpc got %h exp %h", redirect_pc, e); end
    n_vec++; e = exp_q.pop_front();
    if ({31'b0, irq_pending} !== e) begin n_err++; $display("FAIL trap_pend got %b exp 0", irq_pending); end
    irq_timer = 1'b0;
    exp_q.push_back(0);
    @(posedge clk);
    #1 n_vec++; e = exp_q.pop_front();
    if ({31'b0, redirect_valid} !== e) begin n_err++; $display("FAIL trap_rv_once got %b exp 0", redirect_valid); end
    exp_q.push_back(32'h0000_0100); rd(12'h341, got); n_vec++; e = exp_q.pop_front();
    if (got !== e) begin n_err++; $display("FAIL trap_mepc got %h exp %h", got, e); end
    exp_q.push_back(32'h0000_1880); rd(12'h300, got); n_vec++; e = exp_q.pop_front();
    if (got !== e) begin n_err++; $display("FAIL trap_mstatus got %h exp %h", got, e); end
    exp_q.push_back(32'h8000_0007); rd(12'h342, got); n_vec++; e = exp_q.pop_front();
    if (got !== e) begin n_err++; $display("FAIL trap_mcause got %h exp %h", got, e); end
    exp_q.push_back(32'hBAD0_0102); rd(12'h343, got); n_vec++; e = exp_q.pop_front();
    if (got !== e) begin n_err++; $display("FAIL trap_mtval got %h exp %h", got, e); end
  endtask
  task automatic test_vectored;
    wr(2'b01, 12'h305, 32'h0000_0201, ill);
    wr(2'b01, 12'h304, 32'h0000_0888, ill);
    wr(2'b01, 12'h300, 32'h0000_0008, ill);
    @(negedge clk);
    {irq_ext, irq_timer, irq_sw} = 3'b111;
    exp_q.push_back(32'h8000_000B); exp_q.push_back(32'h8000_0003); exp_q.push_back(32'h8000_0007);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 n_vec++; e = exp_q.pop_front();
      if (irq_cause !== e) begin n_err++; $display("FAIL prio%0d got %h exp %h", i, irq_cause, e); end
      @(negedge clk);
      if (i == 0) irq_ext = 1'b0;
      else irq_sw = 1'b0;
    end
    irq_timer = 1'b0;
    exp_q.push_back(32'h0000_022C); exp_q.push_back(32'h0000_0200);
    trap(32'h8000_000B, 32'h0000_0600);
    n_vec++; e = exp_q.pop_front();
    if (redirect_pc !== e) begin n_err++; $display("FAIL vec_irq_rpc got %h exp %h", redirect_pc, e); end
    trap(32'h0000_0002, 32'h0000_0604);
    n_vec++; e = exp_q.pop_front();
    if (redirect_pc !== e) begin n_err++; $display("FAIL vec_exc_rpc got %h exp %h", redirect_pc, e); end
  endtask
  task automatic test_mret;
    wr(2'b01, 12'h341, 32'h0000_0402, ill);
    exp_q.push_back(32'h0000_0400); rd(12'h341, got); n_vec++; e = exp_q.pop_front();
    if (got !== e) begin n_err++; $display("FAIL mepc_align got %h exp %h", got, e); end
    wr(2'b01, 12'h300, 32'h0000_0080, ill);
    @(negedge clk);
    mret_valid = 1'b1;
    exp_q.push_back(1); exp_q.push_back(32'h0000_0400);
    @(posedge clk);
    #1 mret_valid = 1'b0;
    n_vec++; e = exp_q.pop_front();
    if ({31'b0, redirect_valid} !== e) begin n_err++; $display("FAIL mret_rv got %b exp 1", redirect_valid); end
    n_vec++; e = exp_q.pop_front();
    if (redirect_pc !== e) begin n_err++; $display("FAIL mret_rpc got %h exp %h", redirect_pc, e); end
    exp_q.push_back(32'h0000_1888); rd(12'h300, got); n_vec++; e = exp_q.pop_front();
    if (got !== e) begin n_err++; $display("FAIL mret_mstatus got %h exp %h", got, e); end
    exp_q.push_back(0);
    @(posedge clk);
    #1 n_vec++; e = exp_q.pop_front();
    if ({31'b0, redirect_valid} !== e) begin n_err++; $display("FAIL mret_rv_once got %b exp 0", redirect_valid); end
  endtask
  task automatic test_trap_priority;
    wr(2'b01, 12'h340, 32'h1234_5678, ill);
    @(negedge clk);
    csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'hDEAD_BEEF;
    trap_valid = 1'b1; trap_cause = 32'h2; trap_pc = 32'h700;
    exp_q.push_back(0);
    #1 n_vec++; e = exp_q.pop_front();
    if ({31'b0, csr_illegal} !== e) begin n_err++; $display("FAIL trapwr_ill got %b exp 0", csr_illegal); end
    @(posedge clk);
    #1 trap_valid = 1'b0; csr_op = 2'b00;
    @(negedge clk);
    csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h1; mret_valid = 1'b1;
    @(posedge clk);
    #1 mret_valid = 1'b0; csr_op = 2'b00;
    exp_q.push_back(32'h1234_5678); rd(12'h340, got); n_vec++; e = exp_q.pop_front();
    if (got !== e) begin n_err++; $display("FAIL mscratch_kept got %h exp %h", got, e); end
    @(negedge clk);
    csr_op = 2'b01; csr_addr = 12'h7FF; trap_valid = 1'b1;
    exp_q.push_back(0); exp_q.push_back(1);
    #1 n_vec++; e = exp_q.pop_front();
    if ({31'b0, csr_illegal} !== e) begin n_err++; $display("FAIL dropped_ill got %b exp 0", csr_illegal); end
    trap_valid = 1'b0;
    #1 n_vec++; e = exp_q.pop_front();
    if ({31'b0, csr_illegal} !== e) begin n_err++; $display("FAIL unimpl_ill got %b exp 1", csr_illegal); end
    csr_op = 2'b00;
  endtask
  task automatic test_illegal_ro;
    logic [1:0]  ops[4]  = '{2'b01, 2'b10, 2'b11, 2'b01};
    logic [11:0] adrs[4] = '{12'h301, 12'h301, 12'h344, 12'h344};
    logic [31:0] dats[4] = '{32'h0, 32'h0, 32'h0, 32'h800};
    logic        exps[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({31'b0, exps[i]});
      wr(ops[i], adrs[i], dats[i], ill);
      n_vec++; e = exp_q.pop_front();
      if ({31'b0, ill} !== e) begin n_err++; $display("FAIL ro_ill%0d got %b exp %h", i, ill, e); end
    end
    exp_q.push_back(32'h4000_0100); rd(12'h301, got); n_vec++; e = exp_q.pop_front();
    if (got !== e) begin n_err++; $display("FAIL misa_kept got %h exp %h", got, e); end
    exp_q.push_back(0); rd(12'h7FF, got); n_vec++; e = exp_q.pop_front();
    if (got !== e) begin n_err++; $display("FAIL unimpl_rd got %h exp 0", got); end
  endtask
`ifdef CSR_COUNTERS_EN
  task automatic test_counters;
    wr(2'b01, 12'hB80, 32'h0000_0007, ill);
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF, ill);
    exp_q.push_back(32'h0000_0008);
    @(posedge clk);
    rd(12'hB80, got); n_vec++; e = exp_q.pop_front();
    if (got !== e) begin n_err++; $display("FAIL mcycleh_carry got %h exp %h", got, e); end
    instr_retire = 1'b1;
    wr(2'b01, 12'hB02, 32'h0000_0005, ill);
    repeat (3) @(posedge clk);
    #1 instr_retire = 1'b0;
    exp_q.push_back(32'h0000_0008); rd(12'hB02, got); n_vec++; e = exp_q.pop_front();
    if (got !== e) begin n_err++; $display("FAIL minstret got %h exp %h", got, e); end
  endtask
`else
  task automatic test_counters_absent;
    logic [11:0] adrs[4] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      csr_op = 2'b01; csr_addr = adrs[i]; csr_wdata = 32'h55;
      exp_q.push_back(1); exp_q.push_back(0);
      #1 n_vec++; e = exp_q.pop_front();
      if ({31'b0, csr_illegal} !== e) begin n_err++; $display("FAIL cnt_ill%0d got %b exp 1", i, csr_illegal); end
      n_vec++; e = exp_q.pop_front();
      if (csr_rdata !== e) begin n_err++; $display("FAIL cnt_rd%0d got %h exp 0", i, csr_rdata); end
      @(posedge clk);
      #1 csr_op = 2'b00;
    end
    exp_q.push_back(32'h1234_5678); rd(12'h340, got); n_vec++; e = exp_q.pop_front();
    if (got !== e) begin n_err++; $display("FAIL cnt_nochange got %h exp %h", got, e); end
  endtask
`endif
  task automatic test_reset_mid_trap;
    @(negedge clk);
    trap_valid = 1'b1; trap_cause = 32'h3; trap_pc = 32'h500;
    #2 rst = 1'b1;
    exp_q.push_back(0); exp_q.push_back(0);
    #1 n_vec++; e = exp_q.pop_front();
    if ({31'b0, redirect_valid} !== e) begin n_err++; $display("FAIL rst_trap_rv got %b exp 0", redirect_valid); end
    @(posedge clk);
    #1 n_vec++; e = exp_q.pop_front();
    if ({31'b0, redirect_valid} !== e) begin n_err++; $display("FAIL rst_trap_rv2 got %b exp 0", redirect_valid); end
    @(negedge clk);
    trap_valid = 1'b0; rst = 1'b0;
    exp_q.push_back(0);
    @(posedge clk);
    #1 n_vec++; e = exp_q.pop_front();
    if ({31'b0, redirect_valid} !== e) begin n_err++; $display("FAIL rst_trap_rv3 got %b exp 0", redirect_valid); end
    exp_q.push_back(0); rd(12'h341, got); n_vec++; e = exp_q.pop_front();
    if (got !== e) begin n_err++; $display("FAIL rst_mepc got %h exp 0", got); end
    exp_q.push_back(0); rd(12'h340, got); n_vec++; e = exp_q.pop_front();
    if (got !== e) begin n_err++; $display("FAIL rst_mscratch got %h exp 0", got); end
  endtask
  initial begin
    test_reset;
    test_mtvec_warl;
    test_irq_trap;
    test_vectored;
    test_mret;
    test_trap_priority;
    test_illegal_ro;
`ifdef CSR_COUNTERS_EN
    test_counters;
`else
    test_counters_absent;
`endif
    test_reset_mid_trap;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
